// File: rtl/aes_rnd_iter.sv
// Iterative AES encryption core: one full round per clock, round keys fetched from an external combinational key store.
// Latency: o_vld rises Nr+1 cycles after the accept cycle (11/13/15 for AES-128/192/256).
// Backpressure: result is held in DONE until i_rdy; o_rdy stays low from accept until the output handshake.
module aes_rnd_iter #(
  parameter int RND_SIZE = 128,
  parameter int WRD_SIZE = 32,
  parameter int NUM_BLK  = 4,
  parameter int MAX_RND  = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_vld,
  output logic                o_rdy,
  input  logic [RND_SIZE-1:0] i_rnd_text,
  input  logic [1:0]          i_key_len,
  output logic [3:0]          o_key_idx,
  input  logic [RND_SIZE-1:0] i_rnd_key,
  input  logic                i_flush,
  output logic                o_vld,
  input  logic                i_rdy,
  output logic [RND_SIZE-1:0] o_rnd_cypher,
  output logic                o_busy
);

  // Bytes per column word; MixColumns as written is the AES matrix when this is 4.
  localparam int NROW = WRD_SIZE / 8;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Circulant {02,03,01,01} column mix; row 0 is the most significant byte.
  function automatic logic [WRD_SIZE-1:0] mix_col(input logic [WRD_SIZE-1:0] col);
    logic [7:0] a [NROW];
    logic [7:0] o;
    mix_col = '0;
    for (int r = 0; r < NROW; r++) a[r] = col[WRD_SIZE-1-8*r -: 8];
    for (int r = 0; r < NROW; r++) begin
      o = xt(a[r]) ^ xt(a[(r+1)%NROW]) ^ a[(r+1)%NROW];
      for (int k = 2; k < NROW; k++) o = o ^ a[(r+k)%NROW];
      mix_col[WRD_SIZE-1-8*r -: 8] = o;
    end
  endfunction

  fsm_e                fsm_q;
  logic [RND_SIZE-1:0] st_q;
  logic [3:0]          cnt_q;
  logic [3:0]          nr_q;
  logic                rdy_q;
  logic                vld_q;
  logic                busy_q;
  logic [3:0]          kidx_q;

  logic [3:0]          nr_d;
  logic [RND_SIZE-1:0] sr_d;
  logic [RND_SIZE-1:0] st_d;
  logic                last_rnd;

  // The last round is the one whose index matches the latched round count.
  assign last_rnd = (cnt_q == nr_q);

  // Key length select; both upper codes give the longest schedule.
  always_comb begin
    nr_d = 4'(MAX_RND);
    case (i_key_len)
      2'b00:   nr_d = 4'd10;
      2'b01:   nr_d = 4'd12;
      default: nr_d = 4'(MAX_RND);
    endcase
  end

  // SubBytes fused with ShiftRows: row r of column c takes the byte from column c+r.
  for (genvar c = 0; c < NUM_BLK; c++) begin : g_col
    for (genvar r = 0; r < NROW; r++) begin : g_row
      localparam int DHI = RND_SIZE - 1 - c * WRD_SIZE - r * 8;
      localparam int SHI = RND_SIZE - 1 - ((c + r) % NUM_BLK) * WRD_SIZE - r * 8;
      assign sr_d[DHI -: 8] = SBOX[st_q[SHI -: 8]];
    end
    localparam int CHI = RND_SIZE - 1 - c * WRD_SIZE;
    // MixColumns is skipped on the final round, then the round key is added.
    assign st_d[CHI -: WRD_SIZE] =
      (last_rnd ? sr_d[CHI -: WRD_SIZE] : mix_col(sr_d[CHI -: WRD_SIZE])) ^ i_rnd_key[CHI -: WRD_SIZE];
  end

  // Control FSM and datapath state; flush wins over every other transition and leaves st_q alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      st_q   <= '0;
      cnt_q  <= '0;
      nr_q   <= 4'd10;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      kidx_q <= '0;
    end else if (i_flush) begin
      fsm_q  <= IDLE;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      kidx_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (i_vld) begin
            st_q   <= i_rnd_text ^ i_rnd_key;
            nr_q   <= nr_d;
            cnt_q  <= 4'd1;
            fsm_q  <= ROUND;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            kidx_q <= 4'd1;
          end
        end
        ROUND: begin
          st_q  <= st_d;
          cnt_q <= cnt_q + 4'd1;
          if (last_rnd) begin
            fsm_q  <= DONE;
            vld_q  <= 1'b1;
            kidx_q <= '0;
          end else begin
            kidx_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          if (i_rdy) begin
            fsm_q  <= IDLE;
            vld_q  <= 1'b0;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: begin
          fsm_q  <= IDLE;
          rdy_q  <= 1'b1;
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
          kidx_q <= '0;
        end
      endcase
    end
  end

  assign o_rdy        = rdy_q;
  assign o_vld        = vld_q;
  assign o_busy       = busy_q;
  assign o_key_idx    = kidx_q;
  assign o_rnd_cypher = st_q;

endmodule

// File: doc/aes_rnd_iter.md
AES_RND_ITER -- requirements
Module: aes_rnd_iter

Interface
REQ-001 SHALL have parameter RND_SIZE, default 128, state/text/key width in bits.
REQ-002 SHALL have parameter WRD_SIZE, default 32, column word width in bits.
REQ-003 SHALL have parameter NUM_BLK, default 4, number of columns per state (RND_SIZE = WRD_SIZE*NUM_BLK).
REQ-004 SHALL have parameter MAX_RND, default 14, largest supported round count.
REQ-005 SHALL use one clock and an asynchronous, active-low reset. Port clk, input, 1 bit, clock; all state updates occur on its rising edge.
REQ-006 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 Port i_vld, input, 1 bit, input block valid.
REQ-008 Port o_rdy, output, 1 bit, engine ready to accept a block.
REQ-009 Port i_rnd_text, input, RND_SIZE, plaintext block; sampled on accept.
REQ-010 Port i_key_len, input, 2 bits, key size select: 00=10 rounds, 01=12, 10=14, 11=14; sampled on accept.
REQ-011 Port o_key_idx, output, 4 bits, index of the round key required this cycle.
REQ-012 Port i_rnd_key, input, RND_SIZE, round key for o_key_idx, valid in the same cycle (combinational key store).
REQ-013 Port i_flush, input, 1 bit, synchronous abort.
REQ-014 Port o_vld, output, 1 bit, ciphertext valid.
REQ-015 Port i_rdy, input, 1 bit, downstream ready.
REQ-016 Port o_rnd_cypher, output, RND_SIZE, ciphertext block.
REQ-017 Port o_busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ROUND, DONE.
REQ-019 In IDLE: o_rdy=1, o_key_idx=0; accept occurs when i_vld&&o_rdy; on accept, state register <= i_rnd_text XOR i_rnd_key, Nr latched from i_key_len, round counter <= 1, next state ROUND.
REQ-020 In ROUND: o_key_idx = round counter; each cycle state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), i_rnd_key); counter increments.
REQ-021 When counter == Nr, the round SHALL omit MixColumns (final round) and next state SHALL be DONE.
REQ-022 In DONE: o_vld=1, o_rnd_cypher = state register, o_key_idx=0; held stable until i_rdy=1; on o_vld&&i_rdy next state IDLE.
REQ-023 Latency: o_vld SHALL assert exactly Nr+1 cycles after the accept edge (11/13/15 cycles for 00/01/10).
REQ-024 o_rdy SHALL be 0 in ROUND and DONE; no new block is accepted until the DONE handshake completes (no overlap).
REQ-025 i_vld, i_rnd_text and i_key_len SHALL be ignored outside IDLE.
REQ-026 i_flush=1 in any state SHALL force IDLE on the next edge, drop o_vld, and leave the state register unchanged; i_flush has priority over accept and over DONE handshake in the same cycle.
REQ-027 o_rnd_cypher SHALL retain its last value outside DONE (state register is not cleared on completion).
REQ-028 Column operations SHALL be generated over NUM_BLK columns of WRD_SIZE bits; ShiftRows row r rotates left by r columns modulo NUM_BLK.
REQ-029 Round counter SHALL be 4 bits; MAX_RND < 16.

Reset
REQ-030 On rst_n=0, asynchronously: FSM=IDLE, state register=0, counter=0, Nr=10; hence o_rdy=1, o_vld=0, o_busy=0, o_key_idx=0, o_rnd_cypher=0.
REQ-031 Reset asserted mid-operation SHALL discard the block; after release, the engine behaves as after power-up.

Verification
REQ-032 FIPS-197 AES-128: text 00112233445566778899aabbccddeeff, key 000102..0f (bench expands keys), i_key_len=00 -> o_vld at cycle 11, o_rnd_cypher 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-033 AES-192 key 000102..17, same text, i_key_len=01 -> cycle 13, dda97ca4864cdfe06eaf70a0ec0d7191; AES-256 key 000102..1f, i_key_len=10 -> cycle 15, 8ea2b7ca516745bfeafc49904b496089.
REQ-034 Backpressure: hold i_rdy=0 for 5 cycles in DONE -> o_vld and o_rnd_cypher stable, o_rdy=0, i_vld ignored; release -> IDLE next cycle.
REQ-035 Flush: assert i_flush at round 5 -> IDLE next edge, o_vld never asserts, next block completes correctly.
REQ-036 Reset: drop rst_n during round 7 -> outputs at reset values immediately; post-reset AES-128 vector passes.
REQ-037 o_key_idx sequence for AES-256: 0 at accept, 1..14 in ROUND cycles, 0 in DONE.
